// File: rtl/mci_cif_sub_decode_mux_if.sv
// Request/response bus between the MCI AXI subordinate (master side) and
// the CIF decoder (slave side).
//   dv/addr/user/write/wdata : request from the subordinate
//   hold/error/rdata         : stall and response back to the subordinate
interface mci_cif_sub_decode_mux_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned UW = 32
);
  logic          dv;
  logic [AW-1:0] addr;
  logic [UW-1:0] user;
  logic          write;
  logic [DW-1:0] wdata;
  logic          hold;
  logic          error;
  logic [DW-1:0] rdata;

  modport master (output dv, addr, user, write, wdata, input hold, error, rdata);
  modport slave  (input dv, addr, user, write, wdata, output hold, error, rdata);
endinterface

// File: rtl/mci_cif_sub_decode_mux.sv
// N-target CIF decoder between the MCI AXI subordinate and its targets.
// Decodes soc.addr against NUM_TGT aligned power-of-two windows, locks the
// selected target while it holds, returns a registered error on misses and
// hold timeouts, and classifies soc.user against privileged straps.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   soc             slave side of the subordinate request/response bus
//   tgt_*           one-hot valid, broadcast addr/write/wdata, per-target
//                   hold/error/rdata (target i at tgt_rdata[i*DW+:DW])
//   priv_user       privileged user straps, priv_req/soc_req classification
//   timeout_pulse   1-cycle pulse when a hold timeout aborts a transaction
//   proto_err_pulse 1-cycle pulse when soc.dv drops mid-transaction
module mci_cif_sub_decode_mux #(
  parameter int unsigned NUM_TGT  = 3,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned UW       = 32,
  parameter int unsigned NUM_PRIV = 3,
  parameter logic [AW-1:0] TGT_BASE [NUM_TGT] = '{32'h0000_0000, 32'h0000_1000, 32'h0001_0000},
  parameter logic [AW-1:0] TGT_SIZE [NUM_TGT] = '{32'h0000_1000, 32'h0000_1000, 32'h0001_0000},
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  mci_cif_sub_decode_mux_if.slave  soc,
  output logic [NUM_TGT-1:0]       tgt_dv,
  output logic [AW-1:0]            tgt_addr,
  output logic                     tgt_write,
  output logic [DW-1:0]            tgt_wdata,
  input  logic [NUM_TGT-1:0]       tgt_hold,
  input  logic [NUM_TGT-1:0]       tgt_error,
  input  logic [NUM_TGT*DW-1:0]    tgt_rdata,
  input  logic [NUM_PRIV*UW-1:0]   priv_user,
  output logic [NUM_PRIV-1:0]      priv_req,
  output logic                     soc_req,
  output logic                     timeout_pulse,
  output logic                     proto_err_pulse
);

  localparam int unsigned SW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ACTIVE   = 2'd1;
  localparam logic [1:0] ST_MISS_RSP = 2'd2;
  localparam logic [1:0] ST_TO_RSP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_pulse_q, timeout_pulse_d;
  logic          proto_err_pulse_q, proto_err_pulse_d;

  logic               hit;
  logic [SW-1:0]      hit_idx;
  logic [NUM_TGT-1:0] tgt_dv_c;
  logic               hold_c;
  logic               error_c;
  logic [DW-1:0]      rdata_c;
  logic [NUM_PRIV-1:0] priv_req_c;

  // First matching window wins, so overlapping windows resolve to the lowest index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_TGT; i++) begin
      if (!hit && ((soc.addr & ~(TGT_SIZE[i] - AW'(1))) == TGT_BASE[i])) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    sel_d             = sel_q;
    cnt_d             = cnt_q;
    timeout_pulse_d   = 1'b0;
    proto_err_pulse_d = 1'b0;
    tgt_dv_c          = '0;
    hold_c            = 1'b0;
    error_c           = 1'b0;
    rdata_c           = '0;
    case (state_q)
      ST_IDLE: begin
        if (soc.dv) begin
          if (hit) begin
            tgt_dv_c[hit_idx] = 1'b1;
            if (tgt_hold[hit_idx]) begin
              hold_c  = 1'b1;
              sel_d   = hit_idx;
              cnt_d   = CW'(1);
              state_d = ST_ACTIVE;
            end else begin
              error_c = tgt_error[hit_idx];
              rdata_c = tgt_rdata[hit_idx*DW +: DW];
            end
          end else begin
            hold_c  = 1'b1;
            state_d = ST_MISS_RSP;
          end
        end
      end
      ST_ACTIVE: begin
        if (!soc.dv) begin
          state_d           = ST_IDLE;
          proto_err_pulse_d = 1'b1;
        end else if (!tgt_hold[sel_q]) begin
          tgt_dv_c[sel_q] = 1'b1;
          error_c         = tgt_error[sel_q];
          rdata_c         = tgt_rdata[sel_q*DW +: DW];
          state_d         = ST_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES))) begin
          // Abort: withdraw the request and answer with an error next cycle.
          hold_c          = 1'b1;
          timeout_pulse_d = 1'b1;
          state_d         = ST_TO_RSP;
        end else begin
          tgt_dv_c[sel_q] = 1'b1;
          hold_c          = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MISS_RSP, ST_TO_RSP: begin
        error_c = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      sel_q             <= '0;
      cnt_q             <= '0;
      timeout_pulse_q   <= 1'b0;
      proto_err_pulse_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      sel_q             <= sel_d;
      cnt_q             <= cnt_d;
      timeout_pulse_q   <= timeout_pulse_d;
      proto_err_pulse_q <= proto_err_pulse_d;
    end
  end

  always_comb begin
    priv_req_c = '0;
    for (int unsigned i = 0; i < NUM_PRIV; i++) begin
      priv_req_c[i] = soc.dv & (soc.user == priv_user[i*UW +: UW]);
    end
  end

  // FSM-driven outputs are forced low while reset is asserted.
  assign tgt_dv          = tgt_dv_c & {NUM_TGT{~rst}};
  assign soc.hold        = hold_c & ~rst;
  assign soc.error       = error_c & ~rst;
  assign soc.rdata       = rdata_c & {DW{~rst}};
  assign tgt_addr        = soc.addr;
  assign tgt_write       = soc.write;
  assign tgt_wdata       = soc.wdata;
  assign priv_req        = priv_req_c;
  assign soc_req         = soc.dv & ~|priv_req_c;
  assign timeout_pulse   = timeout_pulse_q;
  assign proto_err_pulse = proto_err_pulse_q;

endmodule

// File: tb/tb_mci_cif_sub_decode_mux.sv
// Testbench for mci_cif_sub_decode_mux: two instances (hold timeout 16 and 4)
// share directed stimulus; a transaction-level model checks both every cycle
// and literal expectations pin key cycles.
module tb_mci_cif_sub_decode_mux;

  logic        clk;
  logic        rst;
  logic        dv;
  logic [31:0] addr;
  logic [31:0] user;
  logic        write;
  logic [31:0] wdata;
  logic [2:0]  tgt_hold;
  logic [2:0]  tgt_error;
  logic [95:0] tgt_rdata;
  logic [95:0] priv_user;
  bit          started;

  int n_checks;
  int n_err;

  localparam logic [31:0] BASE [3] = '{32'h0000_0000, 32'h0000_1000, 32'h0001_0000};
  localparam logic [31:0] SIZE [3] = '{32'h0000_1000, 32'h0000_1000, 32'h0001_0000};
  localparam int          TMO  [2] = '{16, 4};

  mci_cif_sub_decode_mux_if #(.AW(32), .DW(32), .UW(32)) if_a ();
  mci_cif_sub_decode_mux_if #(.AW(32), .DW(32), .UW(32)) if_b ();

  assign if_a.dv = dv;  assign if_a.addr = addr;  assign if_a.user = user;
  assign if_a.write = write;  assign if_a.wdata = wdata;
  assign if_b.dv = dv;  assign if_b.addr = addr;  assign if_b.user = user;
  assign if_b.write = write;  assign if_b.wdata = wdata;

  logic [2:0]  dv_a, dv_b, priv_a, priv_b;
  logic [31:0] taddr_a, taddr_b, twdata_a, twdata_b;
  logic        twr_a, twr_b, req_a, req_b, to_a, to_b, pe_a, pe_b;

  mci_cif_sub_decode_mux #(
    .NUM_TGT(3), .AW(32), .DW(32), .UW(32), .NUM_PRIV(3),
    .TGT_BASE(BASE), .TGT_SIZE(SIZE), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk(clk), .rst(rst), .soc(if_a),
    .tgt_dv(dv_a), .tgt_addr(taddr_a), .tgt_write(twr_a), .tgt_wdata(twdata_a),
    .tgt_hold(tgt_hold), .tgt_error(tgt_error), .tgt_rdata(tgt_rdata),
    .priv_user(priv_user), .priv_req(priv_a), .soc_req(req_a),
    .timeout_pulse(to_a), .proto_err_pulse(pe_a)
  );

  mci_cif_sub_decode_mux #(
    .NUM_TGT(3), .AW(32), .DW(32), .UW(32), .NUM_PRIV(3),
    .TGT_BASE(BASE), .TGT_SIZE(SIZE), .TIMEOUT_CYCLES(4)
  ) u_dut_to (
    .clk(clk), .rst(rst), .soc(if_b),
    .tgt_dv(dv_b), .tgt_addr(taddr_b), .tgt_write(twr_b), .tgt_wdata(twdata_b),
    .tgt_hold(tgt_hold), .tgt_error(tgt_error), .tgt_rdata(tgt_rdata),
    .priv_user(priv_user), .priv_req(priv_b), .soc_req(req_b),
    .timeout_pulse(to_b), .proto_err_pulse(pe_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding transaction per instance, which
  // either completes, is waiting on its target, or owes an error response.
  bit m_locked [2];
  int m_tgt    [2];
  int m_age    [2];
  bit m_rsp    [2];
  bit m_to     [2];
  bit m_pe     [2];

  task automatic model_check(input int d, input logic a_hold, input logic a_err,
                             input logic [31:0] a_rdata, input logic [2:0] a_dv,
                             input logic a_to, input logic a_pe, input logic [2:0] a_priv,
                             input logic a_req, input logic [31:0] a_taddr);
    string      tag = (d == 0) ? "main" : "tmo";
    logic [2:0] e_dv = '0;
    logic       e_hold = 1'b0, e_err = 1'b0, valid = 1'b0;
    logic [31:0] e_rdata = '0;
    logic [2:0] e_priv = '0;
    logic       e_to = m_to[d], e_pe = m_pe[d];
    int         h = -1;
    m_to[d] = 1'b0;
    m_pe[d] = 1'b0;
    if (rst) begin
      m_locked[d] = 1'b0;
      m_rsp[d]    = 1'b0;
    end else if (m_rsp[d]) begin
      e_err = 1'b1; valid = 1'b1; m_rsp[d] = 1'b0;
    end else if (m_locked[d]) begin
      if (!dv) begin
        m_locked[d] = 1'b0; m_pe[d] = 1'b1;
      end else if (!tgt_hold[m_tgt[d]]) begin
        e_dv = 3'b001 << m_tgt[d];
        e_err = tgt_error[m_tgt[d]];
        e_rdata = tgt_rdata[m_tgt[d]*32 +: 32];
        valid = 1'b1; m_locked[d] = 1'b0;
      end else if (m_age[d] >= TMO[d]) begin
        e_hold = 1'b1; m_rsp[d] = 1'b1; m_to[d] = 1'b1; m_locked[d] = 1'b0;
      end else begin
        e_dv = 3'b001 << m_tgt[d]; e_hold = 1'b1; m_age[d]++;
      end
    end else if (dv) begin
      for (int i = 2; i >= 0; i--)
        if (addr >= BASE[i] && {1'b0, addr} < {1'b0, BASE[i]} + {1'b0, SIZE[i]}) h = i;
      if (h < 0) begin
        e_hold = 1'b1; m_rsp[d] = 1'b1;
      end else begin
        e_dv = 3'b001 << h;
        if (tgt_hold[h]) begin
          e_hold = 1'b1; m_locked[d] = 1'b1; m_tgt[d] = h; m_age[d] = 1;
        end else begin
          e_err = tgt_error[h]; e_rdata = tgt_rdata[h*32 +: 32]; valid = 1'b1;
        end
      end
    end
    for (int p = 0; p < 3; p++) e_priv[p] = dv && (user == priv_user[p*32 +: 32]);
    chk({tag, "_hold"}, 64'(a_hold), 64'(e_hold));
    chk({tag, "_tgt_dv"}, 64'(a_dv), 64'(e_dv));
    chk({tag, "_timeout_pulse"}, 64'(a_to), 64'(e_to));
    chk({tag, "_proto_err_pulse"}, 64'(a_pe), 64'(e_pe));
    chk({tag, "_priv_req"}, 64'(a_priv), 64'(e_priv));
    chk({tag, "_soc_req"}, 64'(a_req), 64'(dv && e_priv == 3'b000));
    chk({tag, "_tgt_addr"}, 64'(a_taddr), 64'(addr));
    if (valid) begin
      chk({tag, "_error"}, 64'(a_err), 64'(e_err));
      chk({tag, "_rdata"}, 64'(a_rdata), 64'(e_rdata));
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      model_check(0, if_a.hold, if_a.error, if_a.rdata, dv_a, to_a, pe_a, priv_a, req_a, taddr_a);
      model_check(1, if_b.hold, if_b.error, if_b.rdata, dv_b, to_b, pe_b, priv_b, req_b, taddr_b);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; dv = 1'b0; addr = '0; user = '0; write = 1'b0; wdata = '0;
    tgt_hold = '0; tgt_error = '0;
    tgt_rdata = {32'hC222_2222, 32'hB111_1111, 32'hA000_0000};
    priv_user = {32'h0000_0011, 32'h0000_0022, 32'h0000_0011};
    n_checks = 0; n_err = 0; started = 1'b0;
    @(posedge clk);
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_hold", 64'(if_a.hold), 64'd0);
    chk("reset_tgt_dv", 64'(dv_a), 64'd0);
    chk("reset_pulses", 64'({to_a, pe_a, to_b, pe_b}), 64'd0);
    nxt(); rst = 1'b0;

    // hit, no hold: completes in the presenting cycle
    dv = 1'b1; addr = 32'h0000_1004;
    @(negedge clk);
    chk("hit_tgt_dv", 64'(dv_a), 64'b010);
    chk("hit_hold", 64'(if_a.hold), 64'd0);
    chk("hit_rdata", 64'(if_a.rdata), 64'hB111_1111);
    nxt(); addr = 32'h0000_0020; tgt_error = 3'b001;
    @(negedge clk);
    chk("hit_err", 64'(if_a.error), 64'd1);
    nxt(); dv = 1'b0; tgt_error = '0;
    nxt();

    // held lock: target 0 holds 5 cycles while the address moves to target 2
    dv = 1'b1; addr = 32'h0000_0008; tgt_hold = 3'b001;
    @(negedge clk);
    chk("lock_tgt_dv_c0", 64'(dv_a), 64'b001);
    for (int c = 1; c <= 4; c++) begin
      nxt(); addr = 32'h0001_0000;
      @(negedge clk);
      chk($sformatf("lock_tgt_dv_c%0d", c), 64'(dv_a), 64'b001);
      chk($sformatf("lock_hold_c%0d", c), 64'(if_a.hold), 64'd1);
    end
    nxt(); tgt_hold = '0;
    @(negedge clk);
    chk("lock_done_hold", 64'(if_a.hold), 64'd0);
    chk("lock_done_rdata", 64'(if_a.rdata), 64'hA000_0000);
    chk("lock_tmo_inst_err", 64'(if_b.error), 64'd1);
    nxt(); dv = 1'b0;
    nxt();

    // miss: stall one cycle then registered error
    dv = 1'b1; addr = 32'h0000_5000;
    @(negedge clk);
    chk("miss_c0_hold", 64'(if_a.hold), 64'd1);
    chk("miss_c0_tgt_dv", 64'(dv_a), 64'd0);
    nxt();
    @(negedge clk);
    chk("miss_c1_err", 64'(if_a.error), 64'd1);
    chk("miss_c1_hold", 64'(if_a.hold), 64'd0);
    chk("miss_c1_rdata", 64'(if_a.rdata), 64'd0);
    nxt(); dv = 1'b0;
    nxt();

    // timeout on the 4-cycle instance, target 1 stuck
    dv = 1'b1; addr = 32'h0000_1000; tgt_hold = 3'b010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("tmo_tgt_dv_c%0d", c), 64'(dv_b), 64'b010);
      nxt();
    end
    @(negedge clk);
    chk("tmo_abort_tgt_dv", 64'(dv_b), 64'd0);
    chk("tmo_abort_hold", 64'(if_b.hold), 64'd1);
    nxt();
    @(negedge clk);
    chk("tmo_rsp_err", 64'(if_b.error), 64'd1);
    chk("tmo_rsp_hold", 64'(if_b.hold), 64'd0);
    chk("tmo_pulse", 64'(to_b), 64'd1);
    chk("tmo_main_still_held", 64'(dv_a), 64'b010);
    nxt();
    @(negedge clk);
    chk("tmo_pulse_gone", 64'(to_b), 64'd0);
    nxt(); dv = 1'b0;
    nxt(); tgt_hold = '0;
    @(negedge clk);
    chk("drop_pe_main", 64'(pe_a), 64'd1);
    nxt();

    // privilege classification
    dv = 1'b1; addr = 32'h0; user = 32'h11;
    @(negedge clk);
    chk("priv_101", 64'(priv_a), 64'b101);
    chk("priv_101_req", 64'(req_a), 64'd0);
    nxt(); user = 32'h22;
    @(negedge clk);
    chk("priv_010", 64'(priv_a), 64'b010);
    nxt(); user = 32'h33;
    @(negedge clk);
    chk("priv_none_req", 64'(req_a), 64'd1);
    nxt(); dv = 1'b0; user = 32'h11;
    @(negedge clk);
    chk("priv_nodv", 64'({priv_a, req_a}), 64'd0);

    // reset while a transaction is held
    nxt(); dv = 1'b1; user = '0; addr = 32'h0001_0000; tgt_hold = 3'b100;
    @(negedge clk);
    chk("rst_pre_tgt_dv", 64'(dv_a), 64'b100);
    nxt(); rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_outs", 64'({dv_a, if_a.hold, if_a.error}), 64'd0);
    nxt(); rst = 1'b0; dv = 1'b0;
    @(negedge clk);
    chk("rst_after_pulses", 64'({to_a, pe_a}), 64'd0);
    nxt();
    @(negedge clk);
    chk("rst_after_pe", 64'(pe_a), 64'd0);

    // soc_dv dropped while held
    nxt(); dv = 1'b1; addr = 32'h0001_0004;
    nxt();
    nxt(); dv = 1'b0;
    @(negedge clk);
    chk("drop_tgt_dv", 64'(dv_a), 64'd0);
    nxt();
    @(negedge clk);
    chk("drop_pe", 64'(pe_a), 64'd1);
    nxt(); tgt_hold = '0;
    @(negedge clk);
    chk("drop_pe_clear", 64'(pe_a), 64'd0);

    // back-to-back single-cycle transactions
    nxt(); dv = 1'b1; addr = 32'h0;
    @(negedge clk);
    chk("b2b_0", 64'(dv_a), 64'b001);
    nxt(); addr = 32'h0000_1ffc;
    @(negedge clk);
    chk("b2b_1", 64'(dv_a), 64'b010);
    nxt(); addr = 32'h0001_fffc; write = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("b2b_2", 64'(dv_a), 64'b100);
    chk("b2b_write", 64'({twr_a, twdata_a}), {31'd0, 1'b1, 32'hDEAD_BEEF});
    nxt(); dv = 1'b0; write = 1'b0;
    repeat (3) nxt();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
